serial_bit_encoder: RTL and testbench



---
 rtl/sbe_pkg.sv | 23 ++
 rtl/serial_bit_encoder_lsb_prio_enc.sv | 38 +++
 rtl/serial_bit_encoder.sv | 139 +++++++++++++
 tb/tb_serial_bit_encoder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sbe_pkg.sv
// -----------------------------------------------------------------------------
// sbe_pkg
//   Shared types and constants for the serial bit encoder.
//   Contents:
//     state_e       - control FSM states (IDLE, BUSY)
//     SBE_DEFAULT_N - default request-vector width
//     idx_width()   - index width needed to address N request bits
// -----------------------------------------------------------------------------
package sbe_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int unsigned SBE_DEFAULT_N = 4;

  // A width of at least 1 keeps the index port legal even for degenerate N.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_bit_encoder_lsb_prio_enc.sv
// -----------------------------------------------------------------------------
// lsb_prio_enc
//   Combinational lowest-set-bit priority encoder.
//   Ports:
//     vec    [N-1:0]      input vector
//     idx    [IDX_W-1:0]  index of the lowest set bit (0 when vec is zero)
//     any                 at least one bit of vec is set
//     single              exactly one bit of vec is set
// -----------------------------------------------------------------------------
module lsb_prio_enc
  import sbe_pkg::*;
#(
  parameter int unsigned N     = SBE_DEFAULT_N,
  parameter int unsigned IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             any,
  output logic             single
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    // NOTE: every combinational output is given a default before any
    // conditional assignment, so no path leaves it unassigned (no latch).
    idx = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

  assign any    = |vec;
  // Clearing the lowest set bit leaves zero only when one bit was set.
  assign single = any && ((vec & (vec - ONE)) == '0);

endmodule

// File: rtl/serial_bit_encoder.sv
// -----------------------------------------------------------------------------
// serial_bit_encoder
//   Accepts an N-bit request vector and emits the binary index of each set
//   bit, one beat per index, lowest index first. Valid/ready on both sides.
//
//   Ports:
//     clk        clock, rising edge
//     rst        synchronous reset, active-high
//     in_vec     [N-1:0] request vector
//     in_valid   in_vec valid
//     in_ready   block can accept a vector (IDLE)
//     out_idx    [IDX_W-1:0] index of the current set bit (0 when idle)
//     out_last   current beat is the last for this vector
//     out_valid  out_idx/out_last valid
//     out_ready  consumer accepts the current beat
//     out_err    (only with SBE_ZERO_ERR_EN) flagged beat for a zero vector
//
//   Configuration:
//     SBE_ZERO_ERR_EN  when defined, an accepted all-zero vector produces one
//                      beat with out_idx=0, out_last=1, out_err=1 instead of
//                      being silently dropped.
// -----------------------------------------------------------------------------
module serial_bit_encoder
  import sbe_pkg::*;
#(
  parameter int unsigned N     = SBE_DEFAULT_N,
  parameter int unsigned IDX_W = idx_width(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     in_vec,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready
`ifdef SBE_ZERO_ERR_EN
  ,
  output logic             out_err
`endif
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [N-1:0]     pend_q, pend_d;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_any;
  logic             enc_single;
  logic             busy;
  logic             accept;
  logic             last_beat;
`ifdef SBE_ZERO_ERR_EN
  logic             err_q, err_d;
`endif

  lsb_prio_enc #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_enc (
    .vec    (pend_q),
    .idx    (enc_idx),
    .any    (enc_any),
    .single (enc_single)
  );

  assign busy     = (state_q == BUSY);
  assign in_ready = ~busy;
  assign accept   = in_valid & in_ready;

`ifdef SBE_ZERO_ERR_EN
  // The flagged zero-vector beat has pend empty, so it is last by definition.
  assign last_beat = busy & (err_q | enc_single);
  assign out_err   = busy & err_q;
`else
  assign last_beat = busy & enc_single;
`endif

  assign out_valid = busy;
  assign out_idx   = busy ? enc_idx : '0;
  assign out_last  = last_beat;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
`ifdef SBE_ZERO_ERR_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_vec != '0) begin
            pend_d  = in_vec;
            state_d = BUSY;
          end
`ifdef SBE_ZERO_ERR_EN
          else begin
            pend_d  = '0;
            err_d   = 1'b1;
            state_d = BUSY;
          end
`endif
        end
      end
      BUSY: begin
        if (out_ready) begin
          // x & (x-1) drops exactly the lowest set bit, i.e. bit out_idx.
          if (enc_any) pend_d = pend_q & (pend_q - ONE);
          if (last_beat) begin
            state_d = IDLE;
`ifdef SBE_ZERO_ERR_EN
            err_d   = 1'b0;
`endif
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
`ifdef SBE_ZERO_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
`ifdef SBE_ZERO_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_serial_bit_encoder.sv
// -----------------------------------------------------------------------------
// tb_serial_bit_encoder
//   Self-checking bench for serial_bit_encoder (N=4). Expected beats are
//   pushed to a scoreboard queue when a vector is driven and popped by a
//   monitor on every output handshake.
// -----------------------------------------------------------------------------
module tb_serial_bit_encoder;

  localparam int N     = 4;
  localparam int IDX_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     in_vec;
  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             out_valid;
  logic             out_ready;
`ifdef SBE_ZERO_ERR_EN
  logic             out_err;
`endif

  serial_bit_encoder #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_vec    (in_vec),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef SBE_ZERO_ERR_EN
    ,
    .out_err   (out_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             last;
    logic             err;
  } beat_t;

  typedef struct packed {
    logic [N-1:0]          vec;
    logic [2:0]            nb;
    logic [3:0][IDX_W-1:0] idxs;
    logic                  err;
  } vec_rec_t;

  beat_t    exp_q[$];
  vec_rec_t tbl[10];
  int       n_checks = 0;
  int       n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_rec_t mk(input logic [N-1:0] v, input int nb,
                                  input int i0, input int i1, input int i2,
                                  input int i3, input logic e);
    vec_rec_t r;
    r.vec     = v;
    r.nb      = 3'(nb);
    r.idxs[0] = IDX_W'(i0);
    r.idxs[1] = IDX_W'(i1);
    r.idxs[2] = IDX_W'(i2);
    r.idxs[3] = IDX_W'(i3);
    r.err     = e;
    return r;
  endfunction

  task automatic push_beat(input int idx, input logic last, input logic err);
    beat_t b;
    b.idx  = IDX_W'(idx);
    b.last = last;
    b.err  = err;
    exp_q.push_back(b);
  endtask

  // Monitor: every handshake (not masked by reset) pops one expected beat.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {30'd0, out_idx}, 32'hFFFF_FFFF);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        check("beat_idx", {30'd0, out_idx}, {30'd0, e.idx});
        check("beat_last", {31'd0, out_last}, {31'd0, e.last});
`ifdef SBE_ZERO_ERR_EN
        check("beat_err", {31'd0, out_err}, {31'd0, e.err});
`endif
      end
    end
  end

  // Wait for in_ready, present one vector for a single accepting edge.
  task automatic send_vec(input logic [N-1:0] v);
    int t;
    t = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (in_ready !== 1'b1) check("send_timeout", {31'd0, in_ready}, 32'd1);
    in_vec   = v;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Counts busy cycles after acceptance until the block is idle and drained.
  task automatic wait_idle(output int cycles);
    cycles = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (in_ready === 1'b1 && exp_q.size() == 0) return;
      cycles++;
    end
    check("drain_timeout", exp_q.size(), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst       = 1'b1;
    in_vec    = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;

    tbl[0] = mk(4'b1011, 3, 0, 1, 3, 0, 1'b0);
    tbl[1] = mk(4'b0100, 1, 2, 0, 0, 0, 1'b0);
    tbl[2] = mk(4'b0110, 2, 1, 2, 0, 0, 1'b0);
    tbl[3] = mk(4'b1111, 4, 0, 1, 2, 3, 1'b0);
    tbl[4] = mk(4'b1000, 1, 3, 0, 0, 0, 1'b0);
    tbl[5] = mk(4'b0001, 1, 0, 0, 0, 0, 1'b0);
    tbl[6] = mk(4'b1010, 2, 1, 3, 0, 0, 1'b0);
    tbl[7] = mk(4'b0101, 2, 0, 2, 0, 0, 1'b0);
    tbl[8] = mk(4'b1100, 2, 2, 3, 0, 0, 1'b0);
`ifdef SBE_ZERO_ERR_EN
    tbl[9] = mk(4'b0000, 1, 0, 0, 0, 0, 1'b1);
`else
    tbl[9] = mk(4'b0000, 0, 0, 0, 0, 0, 1'b0);
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_idx", {30'd0, out_idx}, 32'd0);
    check("rst_out_last", {31'd0, out_last}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef SBE_ZERO_ERR_EN
    check("rst_out_err", {31'd0, out_err}, 32'd0);
`endif

    // Single bit: one beat, first-beat latency, in_ready right after
    push_beat(2, 1'b1, 1'b0);
    send_vec(4'b0100);
    @(negedge clk);
    check("t1_latency_valid", {31'd0, out_valid}, 32'd1);
    check("t1_busy_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check("t1_gap_in_ready", {31'd0, in_ready}, 32'd1);
    check("t1_gap_out_valid", {31'd0, out_valid}, 32'd0);

    // Table of vectors at full throughput: k beats occupy exactly k cycles
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < int'(tbl[i].nb); j++)
        push_beat(int'(tbl[i].idxs[j]), (j == int'(tbl[i].nb) - 1), tbl[i].err);
      send_vec(tbl[i].vec);
      wait_idle(cyc);
      check($sformatf("tbl_cycles[%0d]", i), cyc, {29'd0, tbl[i].nb});
    end

    // Backpressure: first beat held stable for 3 cycles
    out_ready = 1'b0;
    push_beat(1, 1'b0, 1'b0);
    push_beat(2, 1'b1, 1'b0);
    send_vec(4'b0110);
    for (int c = 0; c < 3; c++) begin
      if (c == 2) out_ready = 1'b1;
      @(negedge clk);
      check($sformatf("t3_hold_idx[%0d]", c), {30'd0, out_idx}, 32'd1);
      check($sformatf("t3_hold_last[%0d]", c), {31'd0, out_last}, 32'd0);
      check($sformatf("t3_hold_valid[%0d]", c), {31'd0, out_valid}, 32'd1);
      @(posedge clk);
      #1;
    end
    wait_idle(cyc);
    check("t3_drained", exp_q.size(), 32'd0);

    // Zero vector
`ifdef SBE_ZERO_ERR_EN
    push_beat(0, 1'b1, 1'b1);
    send_vec(4'b0000);
    @(negedge clk);
    check("t4_err_valid", {31'd0, out_valid}, 32'd1);
    check("t4_err_flag", {31'd0, out_err}, 32'd1);
    @(negedge clk);
    check("t4_err_idle", {31'd0, in_ready}, 32'd1);
`else
    send_vec(4'b0000);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("t4_zero_no_valid[%0d]", c), {31'd0, out_valid}, 32'd0);
      check($sformatf("t4_zero_in_ready[%0d]", c), {31'd0, in_ready}, 32'd1);
    end
`endif

    // Reset mid-operation after the idx=0 handshake
    push_beat(0, 1'b0, 1'b0);
    send_vec(4'b1111);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("t5_no_beat[%0d]", c), {31'd0, out_valid}, 32'd0);
      check($sformatf("t5_in_ready[%0d]", c), {31'd0, in_ready}, 32'd1);
    end
    push_beat(0, 1'b1, 1'b0);
    send_vec(4'b0001);
    wait_idle(cyc);
    check("t5_after_rst_cycles", cyc, 32'd1);

    // in_valid held high across two vectors
    @(negedge clk);
    push_beat(3, 1'b1, 1'b0);
    in_vec   = 4'b1000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    push_beat(0, 1'b1, 1'b0);
    in_vec = 4'b0001;
    @(negedge clk);
    check("t6_busy_in_ready", {31'd0, in_ready}, 32'd0);
    check("t6_first_idx", {30'd0, out_idx}, 32'd3);
    @(negedge clk);
    check("t6_gap_in_ready", {31'd0, in_ready}, 32'd1);
    check("t6_gap_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("t6_second_valid", {31'd0, out_valid}, 32'd1);
    check("t6_second_idx", {30'd0, out_idx}, 32'd0);
    check("t6_second_last", {31'd0, out_last}, 32'd1);
    wait_idle(cyc);

    check("final_scoreboard_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
